credit_stream_sender: RTL

CREDIT_STREAM_SENDER -- requirements
Module: credit_stream_sender

---
 rtl/credit_stream_sender.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/credit_stream_sender.sv
// -----------------------------------------------------------------------------
// credit_stream_sender
//
// Purpose
//   Forwards a valid/ready upstream stream to a receiver that has no ready
//   signal. The receiver owns a buffer of NumCredits entries and returns one
//   credit pulse for every entry it frees. The sender keeps a matching credit
//   counter and transmits only while at least one credit is available.
//
// Handshake
//   Upstream: a beat transfers on a rising edge where src_valid_i and
//   src_ready_o are both 1. src_ready_o never depends combinationally on
//   src_valid_i or src_data_i. Downstream: dst_valid_o is a one-cycle pulse
//   per beat with no back-pressure, and dst_data_o is qualified by it.
//
// Optional feature
//   CREDIT_STREAM_SENDER_INPUT_SPILL_EN
//     undefined (default): no input buffer. src_ready_o = (credits != 0) and
//                          an accepted beat is on dst one cycle later.
//     defined:             a 2-entry input buffer decouples upstream from
//                          credits. src_ready_o = buffer not full and an
//                          accepted beat is on dst two cycles later.
//
// Parameters
//   T           payload type
//   NumCredits  receiver buffer depth and reset credit count (1..255)
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        synchronous active-low reset
//   src_valid_i   upstream beat valid
//   src_ready_o   upstream beat accepted this cycle
//   src_data_i    upstream payload
//   dst_valid_o   one-cycle pulse per transmitted beat (registered)
//   dst_data_o    transmitted payload, holds its value between pulses
//   dst_credit_i  one-cycle pulse returning one credit
//   credit_cnt_o  credits currently available (registered)
//   credit_err_o  sticky: a credit came back while the count was full
// -----------------------------------------------------------------------------
module credit_stream_sender #(
   parameter type         T          = logic,
   parameter int unsigned NumCredits = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               src_valid_i,
   output logic                               src_ready_o,
   input  logic [$bits(T)-1:0]                src_data_i,
   output logic                               dst_valid_o,
   output logic [$bits(T)-1:0]                dst_data_o,
   input  logic                               dst_credit_i,
   output logic [$clog2(NumCredits+1)-1:0]    credit_cnt_o,
   output logic                               credit_err_o
);

   localparam int unsigned    DataW  = $bits(T);
   localparam int unsigned    CntW   = $clog2(NumCredits + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(NumCredits);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   // --------------------------------------------------------------------------
   // Shared signals between the input path and the credit/output logic.
   //   send       : a beat is registered into the dst stage on this edge
   //   send_data  : payload of that beat
   // --------------------------------------------------------------------------
   logic             send;
   logic [DataW-1:0] send_data;

   logic [CntW-1:0]  cnt_q;
   logic             err_q;
   logic             credit_avail;

   logic             dst_valid_q;
   logic [DataW-1:0] dst_data_q;

   assign credit_avail = (cnt_q != '0);

`ifdef CREDIT_STREAM_SENDER_INPUT_SPILL_EN
   // --------------------------------------------------------------------------
   // Two-entry input buffer. Upstream sees only the fill level, so it can keep
   // pushing while credits are exhausted until both entries are occupied.
   // Steady-state streaming keeps one entry in use (push and pop in the same
   // cycle), which preserves one beat per cycle.
   // --------------------------------------------------------------------------
   logic [DataW-1:0] mem [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       fill_q;
   logic             buf_full;
   logic             buf_empty;
   logic             push;

   assign buf_full    = (fill_q == 2'd2);
   assign buf_empty   = (fill_q == 2'd0);

   // Held low during reset so nothing is accepted in the reset cycle.
   assign src_ready_o = rst_ni & ~buf_full;
   assign push        = src_valid_i & src_ready_o;

   // The head beat leaves as soon as a credit is available.
   assign send        = ~buf_empty & credit_avail;
   assign send_data   = mem[rd_ptr_q];

   // Payload storage carries no reset; the fill level decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= src_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fill_q   <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (send) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, send})
            2'b10:   fill_q <= fill_q + 2'd1;
            2'b01:   fill_q <= fill_q - 2'd1;
            default: fill_q <= fill_q;
         endcase
      end
   end
`else
   // --------------------------------------------------------------------------
   // Direct path: the upstream handshake is the send. Ready comes only from the
   // registered credit count (and reset), never from valid or data.
   // --------------------------------------------------------------------------
   assign src_ready_o = rst_ni & credit_avail;
   assign send        = src_valid_i & src_ready_o;
   assign send_data   = src_data_i;
`endif

   // --------------------------------------------------------------------------
   // Credit counter.
   //   send only           : consume one credit
   //   credit only         : regain one credit, or flag an error when full
   //   send and credit     : net zero, count unchanged
   // A send always has count != 0, so the decrement cannot underflow.
   // A returned credit updates the register at the end of its cycle, so it can
   // only raise src_ready_o from the following cycle onward.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= CntMax;
         err_q <= 1'b0;
      end else begin
         if (send && !dst_credit_i) begin
            cnt_q <= cnt_q - CntOne;
         end else if (!send && dst_credit_i) begin
            if (cnt_q == CntMax) begin
               // Receiver returned more credits than exist: drop and remember.
               err_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CntOne;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output stage. dst_valid_o pulses for exactly the cycle after a send;
   // dst_data_o only updates on a send so it holds between pulses.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         dst_valid_q <= send;
         if (send) begin
            dst_data_q <= send_data;
         end
      end
   end

   assign dst_valid_o  = dst_valid_q;
   assign dst_data_o   = dst_data_q;
   assign credit_cnt_o = cnt_q;
   assign credit_err_o = err_q;

endmodule
